// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add a 'sub' port for unsigned subtraction (a - b).
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one sum bit per edge, WIDTH edges total
// DONE  | result on sum/cout, done pulsed for this single cycle

module serial_adder_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-2:0]   s_sh;
   logic               c;
   logic [CNT_W-1:0]   cnt;

   logic               s;
   logic               c_nxt;
   logic [WIDTH-1:0]   s_nxt;
   logic               last_bit;
   logic [WIDTH-1:0]   b_load;
   logic               c_load;

`ifdef SERIAL_ADD_SUB_EN
   // a - b as a + ~b + 1; cout then reads as "no borrow"
   assign b_load = sub ? ~b : b;
   assign c_load = sub | cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   assign s        = a_sh[0] ^ b_sh[0] ^ c;
   assign c_nxt    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
   assign s_nxt    = {s, s_sh};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (last_bit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         s_sh <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b_load;
                  c    <= c_load;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               s_sh <= s_nxt[WIDTH-1:1];
               c    <= c_nxt;
               cnt  <= cnt + CNT_W'(1);
               // ports only ever see the completed result
               if (last_bit) begin
                  sum  <= s_nxt;
                  cout <= c_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); subtraction cases run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int e0 = 0;
   int done_count = 0;
   int last_done_cyc = 0;
   logic [W:0] sb[$];
   int done_cycs[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                        input logic cc, input logic ss);
      if (ss) return {1'b0, aa} + {1'b0, ~bb} + (W+1)'(1);
      return {1'b0, aa} + {1'b0, bb} + (W+1)'(cc);
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         done_count++;
         last_done_cyc = cyc;
         done_cycs.push_back(cyc);
         if (sb.size() == 0) check("sb_underflow", 0, 1);
         else check("result", {cout, sum}, sb.pop_front());
      end
   end

   task automatic drive_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic cc, input logic ss);
      @(negedge clk);
      a = aa; b = bb; cin = cc; sub = ss; start = 1'b1;
      sb.push_back(model(aa, bb, cc, ss));
      @(posedge clk);
      #1;
      e0 = cyc;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy && !done) break;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      int dc;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", {cout, sum}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic add with latency/handshake timing
      drive_op(8'h0F, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_busy_rise", busy, 1);
      wait_idle();
      check("t1_done_cyc", last_done_cyc - e0, 8);
      check("t1_idle_cyc", cyc - e0, 9);
      check("t1_sum", {cout, sum}, 9'h010);

      // carry out, then hold stability across the next operation
      drive_op(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_idle();
      repeat (4) @(negedge clk);
      check("t2_hold_idle", {cout, sum}, 9'h100);
      drive_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("t2_hold_run", {cout, sum}, 9'h100);
      wait_idle();
      check("t2_sum", {cout, sum}, 9'h1FF);

      // start while busy is ignored
      dc = done_count;
      drive_op(8'h12, 8'h34, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();
      repeat (12) @(negedge clk);
      check("t3_one_done", done_count - dc, 1);
      check("t3_sum", {cout, sum}, 9'h046);

      // async reset mid-run
      dc = done_count;
      drive_op(8'h80, 8'h80, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t4_rst_busy", busy, 0);
      check("t4_rst_done", done, 0);
      check("t4_rst_sum", {cout, sum}, 0);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("t4_no_done", done_count - dc, 0);
      drive_op(8'h01, 8'h01, 1'b0, 1'b0);
      wait_idle();
      check("t4_sum", {cout, sum}, 9'h002);

      // start held high: one op per W+2 cycles
      dc = done_count;
      done_cycs.delete();
      @(negedge clk);
      a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
      for (int k = 0; k < 30; k += W + 2) sb.push_back(model(8'h03, 8'h04, 1'b0, 1'b0));
      repeat (30) @(posedge clk);
      #1 start = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      check("t5_done_count", done_count - dc, 3);
      for (int k = 1; k < done_cycs.size(); k++)
         check("t5_period", done_cycs[k] - done_cycs[k-1], W + 2);

      // random adds
      for (int k = 0; k < 8; k++) begin
         drive_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         wait_idle();
      end

`ifdef SERIAL_ADD_SUB_EN
      drive_op(8'h05, 8'h07, 1'b0, 1'b1);
      wait_idle();
      check("sub_borrow", {cout, sum}, 9'h0FE);
      drive_op(8'h07, 8'h05, 1'b0, 1'b1);
      wait_idle();
      check("sub_noborrow", {cout, sum}, 9'h102);
      drive_op(8'h07, 8'h05, 1'b1, 1'b0);
      wait_idle();
      check("sub_off_add", {cout, sum}, 9'h00D);
`endif

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
